// File: rtl/ac97_pkg.sv
// Shared AC'97 frame layout: slot end positions, tag bit indices and receiver FSM states.
// Used by both the SDATA_IN receiver and the SDATA_OUT frame generator.
package ac97_pkg;

  localparam int unsigned SLOT_BITS  = 20;
  localparam int unsigned FRAME_BITS = 256;

  // Bit positions (count_reg values) of the last bit of each region.
  localparam logic [7:0] TAG_LAST   = 8'd15;
  localparam logic [7:0] SLOT1_LAST = 8'd35;
  localparam logic [7:0] SLOT2_LAST = 8'd55;
  localparam logic [7:0] SLOT3_LAST = 8'd75;
  localparam logic [7:0] SLOT4_LAST = 8'd95;
  localparam logic [7:0] FRAME_LAST = 8'd255;

  // Slot 0 tag bit indices.
  localparam int unsigned TAG_READY_BIT = 15;
  localparam int unsigned TAG_SLOT1_BIT = 14;
  localparam int unsigned TAG_SLOT2_BIT = 13;
  localparam int unsigned TAG_SLOT3_BIT = 12;
  localparam int unsigned TAG_SLOT4_BIT = 11;
  localparam int unsigned TAG_FIELD_LSB = 3;
  localparam int unsigned TAG_FIELD_W   = 12;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StRun
  } rx_state_e;

endpackage

// File: rtl/ac97_slot_shift.sv
// MSB-first serial-to-parallel shift register for one AC'97 slot, clocked on the falling
// BIT_CLK edge; reused for every slot of the frame.
module ac97_slot_shift
  import ac97_pkg::*;
(
  input  logic                 bit_clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 shift_i,
  input  logic                 data_i,
  output logic [SLOT_BITS-1:0] q_o
);

  logic [SLOT_BITS-1:0] shift_q, shift_d;

  always_comb begin
    shift_d = shift_q;
    if (clear_i) begin
      shift_d = '0;
    end else if (shift_i) begin
      shift_d = {shift_q[SLOT_BITS-2:0], data_i};
    end
  end

  always_ff @(negedge bit_clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign q_o = shift_q;

endmodule

// File: rtl/ac97_frame_receiver.sv
// AC'97 SDATA_IN deserializer: aligns to SYNC, counts frame bits and latches the tag, status
// address/data and PCM record slots, pulsing a strobe when each group is updated.
module ac97_frame_receiver
  import ac97_pkg::*;
#(
  parameter int unsigned PCM_WIDTH     = 20,
  parameter bit          REQUIRE_READY = 1'b1
) (
  input  logic                 BIT_CLK,
  input  logic                 SYSTEM_RESET,
  input  logic                 SYNC,
  input  logic                 SDATA_IN,
  output logic [7:0]           count_reg,
  output logic                 LOCKED,
  output logic                 CODEC_READY,
  output logic [11:0]          SLOT_TAG,
  output logic [6:0]           STATUS_ADDR,
  output logic [15:0]          STATUS_DATA,
  output logic                 STATUS_VALID,
  output logic [PCM_WIDTH-1:0] PCM_L,
  output logic [PCM_WIDTH-1:0] PCM_R,
  output logic                 PCM_VALID,
  output logic                 FRAME_DONE,
  output logic                 SYNC_ERR
);

  rx_state_e            state_q, state_d;
  logic [7:0]           count_q, count_d;
  logic                 sync_q;
  logic                 locked_q;
  logic                 ready_q;
  logic [11:0]          tag_q;
  logic [6:0]           addr_hold_q;
  logic [PCM_WIDTH-1:0] pcm_l_hold_q;
  logic [6:0]           status_addr_q;
  logic [15:0]          status_data_q;
  logic                 status_valid_q;
  logic [PCM_WIDTH-1:0] pcm_l_q, pcm_r_q;
  logic                 pcm_valid_q;
  logic                 frame_done_q;
  logic                 sync_err_q;

  logic                 sync_rise;
  logic                 shift_clr, shift_en;
  logic [SLOT_BITS-1:0] shift_q;
  logic                 capture_ok, ready_gate;
  logic                 tag_end, slot1_end, slot2_end, slot3_end, slot4_end;
  logic                 status_ok, pcm_ok;

  ac97_slot_shift u_slot_shift (
    .bit_clk_i (BIT_CLK),
    .rst_i     (SYSTEM_RESET),
    .clear_i   (shift_clr),
    .shift_i   (shift_en),
    .data_i    (SDATA_IN),
    .q_o       (shift_q)
  );

  assign sync_rise = SYNC & ~sync_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    shift_clr = 1'b0;
    shift_en  = 1'b0;
    unique case (state_q)
      StIdle: ;
      StArmed: begin
        state_d  = StRun;
        count_d  = '0;
        shift_en = 1'b1;
      end
      StRun: begin
        // Without a new SYNC the counter saturates and the receiver unlocks.
        if (count_q == FRAME_LAST) begin
          state_d = StIdle;
        end else begin
          count_d  = count_q + 8'd1;
          shift_en = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // A SYNC rise always wins: it discards any partial frame and re-arms.
    if (sync_rise) begin
      state_d   = StArmed;
      count_d   = '0;
      shift_clr = 1'b1;
      shift_en  = 1'b0;
    end
  end

  // Slot contents are complete on the edge after the slot's last bit.
  assign capture_ok = (state_q == StRun) && !sync_rise;
  assign tag_end    = capture_ok && (count_q == TAG_LAST);
  assign slot1_end  = capture_ok && (count_q == SLOT1_LAST);
  assign slot2_end  = capture_ok && (count_q == SLOT2_LAST);
  assign slot3_end  = capture_ok && (count_q == SLOT3_LAST);
  assign slot4_end  = capture_ok && (count_q == SLOT4_LAST);

  assign ready_gate = !REQUIRE_READY || ready_q;
  assign status_ok  = slot2_end && ready_gate && tag_q[TAG_SLOT1_BIT - TAG_FIELD_LSB] &&
                      tag_q[TAG_SLOT2_BIT - TAG_FIELD_LSB];
  assign pcm_ok     = slot4_end && ready_gate && tag_q[TAG_SLOT3_BIT - TAG_FIELD_LSB] &&
                      tag_q[TAG_SLOT4_BIT - TAG_FIELD_LSB];

  always_ff @(negedge BIT_CLK or posedge SYSTEM_RESET) begin
    if (SYSTEM_RESET) begin
      state_q        <= StIdle;
      count_q        <= '0;
      sync_q         <= 1'b0;
      locked_q       <= 1'b0;
      ready_q        <= 1'b0;
      tag_q          <= '0;
      addr_hold_q    <= '0;
      pcm_l_hold_q   <= '0;
      status_addr_q  <= '0;
      status_data_q  <= '0;
      status_valid_q <= 1'b0;
      pcm_l_q        <= '0;
      pcm_r_q        <= '0;
      pcm_valid_q    <= 1'b0;
      frame_done_q   <= 1'b0;
      sync_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      sync_q         <= SYNC;
      locked_q       <= (state_d != StIdle);
      status_valid_q <= status_ok;
      pcm_valid_q    <= pcm_ok;
      frame_done_q   <= (state_q == StRun) && (count_q == FRAME_LAST);
      sync_err_q     <= sync_rise && locked_q && (count_q != FRAME_LAST);
      if (tag_end) begin
        ready_q <= shift_q[TAG_READY_BIT];
        tag_q   <= shift_q[TAG_READY_BIT-1 -: TAG_FIELD_W];
      end
      // Slot 1 address (bits 18:12) is held until slot 2 decides whether it is published.
      if (slot1_end) begin
        addr_hold_q <= shift_q[18:12];
      end
      if (status_ok) begin
        status_addr_q <= addr_hold_q;
        status_data_q <= shift_q[19:4];
      end
      if (slot3_end) begin
        pcm_l_hold_q <= shift_q[SLOT_BITS-1 -: PCM_WIDTH];
      end
      if (pcm_ok) begin
        pcm_l_q <= pcm_l_hold_q;
        pcm_r_q <= shift_q[SLOT_BITS-1 -: PCM_WIDTH];
      end
    end
  end

  assign count_reg    = count_q;
  assign LOCKED       = locked_q;
  assign CODEC_READY  = ready_q;
  assign SLOT_TAG     = tag_q;
  assign STATUS_ADDR  = status_addr_q;
  assign STATUS_DATA  = status_data_q;
  assign STATUS_VALID = status_valid_q;
  assign PCM_L        = pcm_l_q;
  assign PCM_R        = pcm_r_q;
  assign PCM_VALID    = pcm_valid_q;
  assign FRAME_DONE   = frame_done_q;
  assign SYNC_ERR     = sync_err_q;

endmodule
